// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch front end.
//
// Issues reads to a synchronous instruction memory at the current PC and
// drives the next PC back into the external PC register. Each returned word
// is stored in a DEPTH-entry FIFO together with its address and handed to
// decode over a valid/ready handshake. A redirect (branch/jump) flushes the
// FIFO, discards any response arriving in that cycle, and restarts fetch at
// the word-aligned target.
//
// Ports
//   CLK, RESET_N        clock (rising edge), asynchronous active-low reset
//   PC / PC_in          current PC from, next PC to, the PC register
//   IMEM_REQ/ADDR       read strobe and address (= PC) to instruction memory
//   IMEM_RDATA          read data, valid the cycle after IMEM_REQ
//   REDIRECT_VALID/PC   taken branch/jump and its target
//   INSTR_VALID/READY   head-of-FIFO handshake with decode
//   INSTR, INSTR_PC     head instruction word and its address
//   FIFO_COUNT          occupied FIFO entries
//
// The fetch control is a three-state machine (RUN / HOLD / FLUSH), but each
// state is fully determined by the current credit and REDIRECT_VALID, so no
// state register is kept:
//   RUN   = credit & ~REDIRECT_VALID   (issue, PC advances)
//   HOLD  = ~credit & ~REDIRECT_VALID  (no issue, PC held)
//   FLUSH = REDIRECT_VALID             (no issue, PC <- target)
module fetch_unit #(
    parameter int size  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [size-1:0]          PC,
    output logic [size-1:0]          PC_in,
    output logic                     IMEM_REQ,
    output logic [size-1:0]          IMEM_ADDR,
    input  logic [31:0]              IMEM_RDATA,
    input  logic                     REDIRECT_VALID,
    input  logic [size-1:0]          REDIRECT_PC,
    output logic                     INSTR_VALID,
    input  logic                     INSTR_READY,
    output logic [31:0]              INSTR,
    output logic [size-1:0]          INSTR_PC,
    output logic [$clog2(DEPTH):0]   FIFO_COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            inflight_q;
    logic [size-1:0] inflight_pc_q;
    logic [31:0]     data_q [DEPTH];
    logic [size-1:0] addr_q [DEPTH];

    logic            pop, credit, push, deq;
    logic [CW:0]     occupancy;

    // Target low bits are forced to zero; they are intentionally ignored.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^REDIRECT_PC[1:0];

    assign INSTR_VALID = (count_q != '0);
    assign INSTR       = data_q[rd_ptr_q];
    assign INSTR_PC    = addr_q[rd_ptr_q];
    assign FIFO_COUNT  = count_q;

    assign pop = INSTR_VALID & INSTR_READY;

    // Slots committed after this cycle: stored words plus the outstanding
    // response, minus the word leaving now. Issuing only below DEPTH means a
    // response always finds a free slot, so the FIFO can never overflow.
    // pop implies count_q >= 1, so this cannot underflow.
    assign occupancy = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign credit    = (occupancy < (CW+1)'(DEPTH));

    assign IMEM_REQ  = RESET_N & credit & ~REDIRECT_VALID;
    assign IMEM_ADDR = PC;

    // A redirect kills the response of the current cycle and any pop; no
    // request issues during a redirect, so nothing stale arrives afterwards.
    assign push = inflight_q & ~REDIRECT_VALID;
    assign deq  = pop & ~REDIRECT_VALID;

    assign count_d = count_q + CW'(push) - CW'(deq);

    always_comb begin
        PC_in = PC;
        if (RESET_N) begin
            if (REDIRECT_VALID)
                PC_in = {REDIRECT_PC[size-1:2], 2'b00};
            else if (IMEM_REQ)
                PC_in = PC + size'(4);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q <= IMEM_REQ;
            if (IMEM_REQ)
                inflight_pc_q <= PC;
            if (REDIRECT_VALID) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push)
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                if (deq)
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                count_q <= count_d;
            end
        end
    end

    // Payload storage needs no reset: entries are only read while counted.
    always_ff @(posedge CLK) begin
        if (push) begin
            data_q[wr_ptr_q] <= IMEM_RDATA;
            addr_q[wr_ptr_q] <= inflight_pc_q;
        end
    end

endmodule
